// File: rtl/stonyman_pkg.sv
// Shared definitions for the two-camera Stonyman ADC arbiter: FSM encoding,
// requester count and default sample width.
package stonyman_pkg;

    localparam int NUM_REQ            = 2;
    localparam int DEFAULT_DATA_WIDTH = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ABORT = 2'd2
    } state_t;

endpackage

// File: rtl/stonyman_edge_detect.sv
// Registers one camera's adc_capture_start and flags its rising edge.
module stonyman_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic rise
);

    logic start_q_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            start_q_reg <= 1'b0;
        end else begin
            start_q_reg <= start;
        end
    end

    assign rise = start & ~start_q_reg;

endmodule

// File: rtl/stonyman_adc_arbiter.sv
// Round-robin sharing of one ADC start/done channel between two Stonyman camera
// controllers. Optional watchdog/abort path is enabled by STONYMAN_ADC_TIMEOUT_EN.
module stonyman_adc_arbiter
    import stonyman_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cam0_adc_capture_start,
    input  logic                  cam1_adc_capture_start,
    output logic                  cam0_adc_capture_done,
    output logic                  cam1_adc_capture_done,
    output logic [DATA_WIDTH-1:0] cam0_pixel_data,
    output logic [DATA_WIDTH-1:0] cam1_pixel_data,
    output logic                  adc_start,
    input  logic                  adc_done,
    input  logic [DATA_WIDTH-1:0] adc_data,
    output logic                  grant_id,
    output logic                  busy,
    output logic                  overrun
`ifdef STONYMAN_ADC_TIMEOUT_EN
    ,
    output logic                  timeout_err
`endif
);

    logic [NUM_REQ-1:0]    start_vec;
    logic [NUM_REQ-1:0]    rise_vec;
    logic [NUM_REQ-1:0]    pending_reg;
    logic [NUM_REQ-1:0]    pending_clr;
    logic [NUM_REQ-1:0]    pending_next;
    logic [NUM_REQ-1:0]    done_reg;
    logic [DATA_WIDTH-1:0] pixel_reg [NUM_REQ];
    state_t                state_reg;
    logic                  grant_reg;
    logic                  last_grant_reg;
    logic                  adc_start_reg;
    logic                  busy_reg;
    logic                  overrun_reg;
    logic                  winner;

`ifdef STONYMAN_ADC_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    logic [TIMER_W-1:0] timer_reg;
    logic               timeout_err_reg;
`endif

    assign start_vec = {cam1_adc_capture_start, cam0_adc_capture_start};

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            stonyman_edge_detect u_edge (
                .clk   (clk),
                .reset (reset),
                .start (start_vec[gi]),
                .rise  (rise_vec[gi])
            );
        end
    endgenerate

    // On a tie the requester that did not own the last conversion wins.
    always_comb begin
        winner = (pending_reg == {NUM_REQ{1'b1}}) ? ~last_grant_reg : pending_reg[1];
        pending_clr = '0;
        if (state_reg == ST_WAIT && adc_done) begin
            pending_clr[grant_reg] = 1'b1;
        end
`ifdef STONYMAN_ADC_TIMEOUT_EN
        if (state_reg == ST_ABORT) begin
            pending_clr[grant_reg] = 1'b1;
        end
`endif
        // A new request on the clearing edge survives.
        pending_next = (pending_reg & ~pending_clr) | rise_vec;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            pending_reg    <= '0;
            last_grant_reg <= 1'b1;
            grant_reg      <= 1'b0;
            adc_start_reg  <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= '0;
            overrun_reg    <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                pixel_reg[i] <= '0;
            end
`ifdef STONYMAN_ADC_TIMEOUT_EN
            timer_reg       <= '0;
            timeout_err_reg <= 1'b0;
`endif
        end else begin
            adc_start_reg <= 1'b0;
            done_reg      <= '0;
            pending_reg   <= pending_next;
            if (|(rise_vec & pending_reg)) begin
                overrun_reg <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (|pending_reg) begin
                        grant_reg      <= winner;
                        last_grant_reg <= winner;
                        adc_start_reg  <= 1'b1;
                        busy_reg       <= 1'b1;
                        state_reg      <= ST_WAIT;
`ifdef STONYMAN_ADC_TIMEOUT_EN
                        timer_reg      <= '0;
`endif
                    end
                end
                ST_WAIT: begin
                    if (adc_done) begin
                        pixel_reg[grant_reg] <= adc_data;
                        done_reg[grant_reg]  <= 1'b1;
                        busy_reg             <= 1'b0;
                        state_reg            <= ST_IDLE;
                    end
`ifdef STONYMAN_ADC_TIMEOUT_EN
                    else if (timer_reg == TIMER_LAST) begin
                        busy_reg  <= 1'b0;
                        state_reg <= ST_ABORT;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
`endif
                end
`ifdef STONYMAN_ADC_TIMEOUT_EN
                ST_ABORT: begin
                    pixel_reg[grant_reg] <= '1;
                    done_reg[grant_reg]  <= 1'b1;
                    timeout_err_reg      <= 1'b1;
                    state_reg            <= ST_IDLE;
                end
`endif
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign cam0_adc_capture_done = done_reg[0];
    assign cam1_adc_capture_done = done_reg[1];
    assign cam0_pixel_data       = pixel_reg[0];
    assign cam1_pixel_data       = pixel_reg[1];
    assign adc_start             = adc_start_reg;
    assign grant_id              = grant_reg;
    assign busy                  = busy_reg;
    assign overrun               = overrun_reg;
`ifdef STONYMAN_ADC_TIMEOUT_EN
    assign timeout_err           = timeout_err_reg;
`endif

endmodule

// File: tb/tb_stonyman_adc_arbiter.sv
// Directed vector bench for stonyman_adc_arbiter, plus hand sequences for
// held starts, re-request on done, reset mid-conversion and (optionally) timeout.
module tb_stonyman_adc_arbiter;

    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          s0 = 1'b0;
    logic          s1 = 1'b0;
    logic          done0;
    logic          done1;
    logic [DW-1:0] pix0;
    logic [DW-1:0] pix1;
    logic          adc_start;
    logic          adc_done = 1'b0;
    logic [DW-1:0] adc_data = '0;
    logic          grant_id;
    logic          busy;
    logic          overrun;
`ifdef STONYMAN_ADC_TIMEOUT_EN
    logic          timeout_err;
`endif

    int n_cmp = 0;
    int n_err = 0;

    stonyman_adc_arbiter #(
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .cam0_adc_capture_start (s0),
        .cam1_adc_capture_start (s1),
        .cam0_adc_capture_done  (done0),
        .cam1_adc_capture_done  (done1),
        .cam0_pixel_data        (pix0),
        .cam1_pixel_data        (pix1),
        .adc_start              (adc_start),
        .adc_done               (adc_done),
        .adc_data               (adc_data),
        .grant_id               (grant_id),
        .busy                   (busy),
        .overrun                (overrun)
`ifdef STONYMAN_ADC_TIMEOUT_EN
        ,
        .timeout_err            (timeout_err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic          rst, st0, st1, dn;
        logic [DW-1:0] data;
        logic          e_start, e_d0, e_d1, e_busy, e_grant, e_ovr;
        logic [DW-1:0] e_p0, e_p1;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, a, b, d, input logic [DW-1:0] dat,
                       input logic es, ed0, ed1, eb, eg, eo,
                       input logic [DW-1:0] p0, p1);
        vec_t v;
        v.rst = r; v.st0 = a; v.st1 = b; v.dn = d; v.data = dat;
        v.e_start = es; v.e_d0 = ed0; v.e_d1 = ed1; v.e_busy = eb;
        v.e_grant = eg; v.e_ovr = eo; v.e_p0 = p0; v.e_p1 = p1;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; s0 = 1'b0; s1 = 1'b0; adc_done = 1'b0; adc_data = '0;
        tick();
        reset = 1'b0;
    endtask

    int n_start, n_d0, n_d1, n;

    initial begin
        // rst st0 st1 dn data | start d0 d1 busy grant ovr | pix0 pix1
        add(1, 0, 0, 0, 12'h000,  0, 0, 0, 0, 0, 0,  12'h000, 12'h000);
        // single request on camera 0, data two cycles after adc_start
        add(0, 1, 0, 0, 12'h000,  0, 0, 0, 0, 0, 0,  12'h000, 12'h000);
        add(0, 1, 0, 0, 12'h000,  1, 0, 0, 1, 0, 0,  12'h000, 12'h000);
        add(0, 0, 0, 0, 12'h000,  0, 0, 0, 1, 0, 0,  12'h000, 12'h000);
        add(0, 0, 0, 1, 12'h3A5,  0, 1, 0, 0, 0, 0,  12'h3A5, 12'h000);
        add(0, 0, 0, 0, 12'h000,  0, 0, 0, 0, 0, 0,  12'h3A5, 12'h000);
        add(0, 0, 0, 1, 12'h111,  0, 0, 0, 0, 0, 0,  12'h3A5, 12'h000);
        // reset, then two simultaneous pairs
        add(1, 0, 0, 0, 12'h000,  0, 0, 0, 0, 0, 0,  12'h000, 12'h000);
        add(0, 1, 1, 0, 12'h000,  0, 0, 0, 0, 0, 0,  12'h000, 12'h000);
        add(0, 1, 1, 0, 12'h000,  1, 0, 0, 1, 0, 0,  12'h000, 12'h000);
        add(0, 0, 0, 1, 12'h0AA,  0, 1, 0, 0, 0, 0,  12'h0AA, 12'h000);
        add(0, 0, 0, 0, 12'h000,  1, 0, 0, 1, 1, 0,  12'h0AA, 12'h000);
        add(0, 0, 0, 1, 12'h155,  0, 0, 1, 0, 1, 0,  12'h0AA, 12'h155);
        add(0, 1, 1, 0, 12'h000,  0, 0, 0, 0, 1, 0,  12'h0AA, 12'h155);
        add(0, 1, 1, 0, 12'h000,  1, 0, 0, 1, 0, 0,  12'h0AA, 12'h155);
        add(0, 0, 0, 1, 12'h7FF,  0, 1, 0, 0, 0, 0,  12'h7FF, 12'h155);
        add(0, 0, 0, 0, 12'h000,  1, 0, 0, 1, 1, 0,  12'h7FF, 12'h155);
        add(0, 0, 0, 1, 12'h800,  0, 0, 1, 0, 1, 0,  12'h7FF, 12'h800);
        add(0, 0, 0, 0, 12'h000,  0, 0, 0, 0, 1, 0,  12'h7FF, 12'h800);
        // camera 0 re-requests while pending
        add(0, 1, 0, 0, 12'h000,  0, 0, 0, 0, 1, 0,  12'h7FF, 12'h800);
        add(0, 0, 0, 0, 12'h000,  1, 0, 0, 1, 0, 0,  12'h7FF, 12'h800);
        add(0, 1, 0, 0, 12'h000,  0, 0, 0, 1, 0, 1,  12'h7FF, 12'h800);
        add(0, 0, 0, 1, 12'h123,  0, 1, 0, 0, 0, 1,  12'h123, 12'h800);
        add(0, 0, 0, 0, 12'h000,  0, 0, 0, 0, 0, 1,  12'h123, 12'h800);
        add(0, 0, 0, 0, 12'h000,  0, 0, 0, 0, 0, 1,  12'h123, 12'h800);

        tick();
        tick();
        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst; s0 = vecs[i].st0; s1 = vecs[i].st1;
            adc_done = vecs[i].dn; adc_data = vecs[i].data;
            tick();
            $display("vec %0d: rst=%0b s0=%0b s1=%0b dn=%0b -> start=%0b d0=%0b d1=%0b busy=%0b gnt=%0b ovr=%0b p0=%h p1=%h",
                     i, reset, s0, s1, adc_done, adc_start, done0, done1, busy, grant_id, overrun, pix0, pix1);
            chk($sformatf("v%0d adc_start", i), 32'(adc_start), 32'(vecs[i].e_start));
            chk($sformatf("v%0d done0", i),     32'(done0),     32'(vecs[i].e_d0));
            chk($sformatf("v%0d done1", i),     32'(done1),     32'(vecs[i].e_d1));
            chk($sformatf("v%0d busy", i),      32'(busy),      32'(vecs[i].e_busy));
            chk($sformatf("v%0d grant_id", i),  32'(grant_id),  32'(vecs[i].e_grant));
            chk($sformatf("v%0d overrun", i),   32'(overrun),   32'(vecs[i].e_ovr));
            chk($sformatf("v%0d pix0", i),      32'(pix0),      32'(vecs[i].e_p0));
            chk($sformatf("v%0d pix1", i),      32'(pix1),      32'(vecs[i].e_p1));
        end

        // Camera 1 start held for 50 cycles, ADC answers one cycle after adc_start
        do_reset();
        n_start = 0; n_d0 = 0; n_d1 = 0;
        for (int c = 0; c < 60; c++) begin
            s1 = (c < 50);
            adc_data = 12'h5A5;
            tick();
            if (adc_start) n_start++;
            if (done0) n_d0++;
            if (done1) n_d1++;
            adc_done = adc_start;
        end
        adc_done = 1'b0;
        $display("held start: starts=%0d done0=%0d done1=%0d pix1=%h", n_start, n_d0, n_d1, pix1);
        chk("held adc_start count", 32'(n_start), 32'd1);
        chk("held done1 count", 32'(n_d1), 32'd1);
        chk("held done0 count", 32'(n_d0), 32'd0);
        chk("held pix1", 32'(pix1), 32'h5A5);

        // Re-request on the same edge as its own done
        do_reset();
        s0 = 1'b1; tick();
        s0 = 1'b0; tick();
        chk("rereq first start", 32'(adc_start), 32'd1);
        tick();
        s0 = 1'b1; adc_done = 1'b1; adc_data = 12'h321; tick();
        $display("rereq done: d0=%0b pix0=%h", done0, pix0);
        chk("rereq done0", 32'(done0), 32'd1);
        chk("rereq pix0", 32'(pix0), 32'h321);
        s0 = 1'b0; adc_done = 1'b0; tick();
        $display("rereq second grant: start=%0b gnt=%0b", adc_start, grant_id);
        chk("rereq second start", 32'(adc_start), 32'd1);
        chk("rereq second grant", 32'(grant_id), 32'd0);
        adc_done = 1'b1; adc_data = 12'h456; tick();
        chk("rereq second done0", 32'(done0), 32'd1);
        chk("rereq second pix0", 32'(pix0), 32'h456);
        adc_done = 1'b0; tick();
        chk("rereq no third start", 32'(adc_start), 32'd0);
        chk("rereq idle busy", 32'(busy), 32'd0);

        // Reset while waiting, then a stale adc_done
        do_reset();
        s1 = 1'b1; tick();
        s1 = 1'b0; tick();
        chk("midrst grant1", 32'(grant_id), 32'd1);
        tick();
        chk("midrst busy", 32'(busy), 32'd1);
        reset = 1'b1; tick();
        reset = 1'b0; adc_done = 1'b1; adc_data = 12'hABC; tick();
        adc_done = 1'b0;
        $display("midrst stale done: d0=%0b d1=%0b pix1=%h busy=%0b gnt=%0b", done0, done1, pix1, busy, grant_id);
        chk("midrst done1", 32'(done1), 32'd0);
        chk("midrst done0", 32'(done0), 32'd0);
        chk("midrst pix1", 32'(pix1), 32'h000);
        chk("midrst busy after", 32'(busy), 32'd0);
        chk("midrst grant_id", 32'(grant_id), 32'd0);
        tick();
        chk("midrst no start", 32'(adc_start), 32'd0);

`ifdef STONYMAN_ADC_TIMEOUT_EN
        // No adc_done: watchdog aborts after 16 waiting cycles
        do_reset();
        s1 = 1'b1; tick();
        s1 = 1'b0; tick();
        n = 0;
        while (!done1 && n < 40) begin
            tick();
            n++;
        end
        $display("timeout: cycles=%0d d1=%0b pix1=%h err=%0b", n, done1, pix1, timeout_err);
        chk("timeout done1", 32'(done1), 32'd1);
        chk("timeout latency", 32'(n), 32'd17);
        chk("timeout pix1", 32'(pix1), 32'hFFF);
        chk("timeout err", 32'(timeout_err), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
